// File: rtl/uart_pkg.sv
// Shared UART definitions: default divisor widths, the minimum usable
// integer divisor and the auto-baud measurement state encoding.
package uart_pkg;

  localparam int DIV_W_DEF    = 16;
  localparam int FRAC_W_DEF   = 8;
  localparam int BAUD_MIN_DIV = 2;

  typedef enum logic [1:0] {
    ABD_IDLE      = 2'd0,
    ABD_WAIT_FALL = 2'd1,
    ABD_MEASURE   = 2'd2,
    ABD_LOAD      = 2'd3
  } abd_state_t;

endpackage

// File: rtl/baud_autobaud.sv
// Auto-baud measurement: times the low pulse on rxd (one start bit with a
// 0x55-style pattern, or a break-free low bit) in clk cycles and converts the
// count into an integer/fractional oversample divisor for the shadow register.
module baud_autobaud
  import uart_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int OVS    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rxd,
  output logic              ld,
  output logic [DIV_W-1:0]  ld_div,
  output logic [FRAC_W-1:0] ld_frac,
  output logic              busy,
  output logic              err
);

  localparam int OS_W = $clog2(OVS);
  localparam int M_W  = DIV_W + OS_W;
  // Last count value from which one more increment would hit the ceiling.
  localparam logic [M_W-1:0] M_LAST = {{(M_W-1){1'b1}}, 1'b0};

  abd_state_t     state_reg, state_next;
  logic [M_W-1:0] m_reg, m_next;
  logic           err_reg, err_next;
  logic           rxd_prev_reg;

  // State, measurement count, sticky error and the rxd history for edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ABD_IDLE;
      m_reg        <= '0;
      err_reg      <= 1'b0;
      rxd_prev_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      m_reg        <= m_next;
      err_reg      <= err_next;
      rxd_prev_reg <= rxd;
    end
  end

  // Next-state logic; a new start always restarts the measurement.
  always_comb begin
    state_next = state_reg;
    m_next     = m_reg;
    err_next   = err_reg;
    ld         = 1'b0;
    if (start) begin
      state_next = ABD_WAIT_FALL;
      err_next   = 1'b0;
      m_next     = '0;
    end else begin
      case (state_reg)
        ABD_IDLE: begin
          state_next = ABD_IDLE;
        end
        ABD_WAIT_FALL: begin
          // The falling-edge cycle is the first low cycle of the pulse.
          if (rxd_prev_reg && !rxd) begin
            state_next = ABD_MEASURE;
            m_next     = {{(M_W-1){1'b0}}, 1'b1};
          end
        end
        ABD_MEASURE: begin
          if (rxd) begin
            state_next = ABD_LOAD;
          end else if (m_reg == M_LAST) begin
            err_next   = 1'b1;
            state_next = ABD_IDLE;
          end else begin
            m_next = m_reg + 1'b1;
          end
        end
        ABD_LOAD: begin
          ld         = 1'b1;
          state_next = ABD_IDLE;
        end
        default: state_next = ABD_IDLE;
      endcase
    end
  end

  assign busy   = (state_reg != ABD_IDLE);
  assign err    = err_reg;
  assign ld_div = m_reg[M_W-1:OS_W];

  // Remainder of M/OVS rescaled from 1/OVS units to 1/2^FRAC_W units.
  generate
    if (FRAC_W > OS_W) begin : g_frac_up
      assign ld_frac = {m_reg[OS_W-1:0], {(FRAC_W-OS_W){1'b0}}};
    end else if (FRAC_W == OS_W) begin : g_frac_eq
      assign ld_frac = m_reg[OS_W-1:0];
    end else begin : g_frac_dn
      assign ld_frac = m_reg[OS_W-1 -: FRAC_W];
    end
  endgenerate

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: oversample, mid-bit and bit ticks from a
// runtime integer+fractional divisor, with receiver phase resync and
// bit-aligned divisor updates through a shadow register.
// Optional auto-baud measurement is built when BAUD_GEN_AUTOBAUD_EN is defined.
module baud_gen_frac
  import uart_pkg::*;
#(
  parameter int DIV_W        = DIV_W_DEF,
  parameter int FRAC_W       = FRAC_W_DEF,
  parameter int OVS          = 16,
  parameter int DEFAULT_DIV  = 27,
  parameter int DEFAULT_FRAC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sync,
  input  logic              cfg_wr,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [FRAC_W-1:0] cfg_frac,
  output logic              cfg_busy,
  output logic              tick_os,
  output logic              tick_mid,
  output logic              tick_bit,
  input  logic              abd_start,
  input  logic              rxd,
  output logic              abd_busy,
  output logic              abd_err
);

  localparam int OS_W = $clog2(OVS);

  logic [DIV_W-1:0]  div_reg, shadow_div_reg;
  logic [FRAC_W-1:0] frac_reg, shadow_frac_reg;
  logic              cfg_busy_reg;
  logic [DIV_W:0]    cnt_reg;
  logic [OS_W-1:0]   os_cnt_reg;
  logic [FRAC_W-1:0] acc_reg;
  logic              extra_reg;

  logic [DIV_W:0]    div_eff;
  logic [DIV_W:0]    period_last;
  logic [FRAC_W:0]   acc_sum;
  logic              apply;
  logic              wr_req;
  logic [DIV_W-1:0]  wr_div;
  logic [FRAC_W-1:0] wr_frac;

  logic              abd_ld;
  logic [DIV_W-1:0]  abd_div;
  logic [FRAC_W-1:0] abd_frac;

  // Divisors below the minimum would make a tick every cycle or never.
  assign div_eff     = (div_reg < DIV_W'(BAUD_MIN_DIV)) ? (DIV_W+1)'(BAUD_MIN_DIV)
                                                        : {1'b0, div_reg};
  assign period_last = extra_reg ? div_eff : (div_eff - 1'b1);
  assign acc_sum     = {1'b0, acc_reg} + {1'b0, frac_reg};

  // ">=" rather than "==" so a divisor shrunk while disabled cannot strand cnt.
  assign tick_os  = enable && !sync && (cnt_reg >= period_last);
  assign tick_bit = tick_os && (os_cnt_reg == OS_W'(OVS-1));
  assign tick_mid = tick_os && (os_cnt_reg == OS_W'(OVS/2-1));
  assign cfg_busy = cfg_busy_reg;

  // Phase counters and the fractional accumulator; sync zeroes the phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg    <= '0;
      os_cnt_reg <= '0;
      acc_reg    <= '0;
      extra_reg  <= 1'b0;
    end else if (sync) begin
      cnt_reg    <= '0;
      os_cnt_reg <= '0;
      acc_reg    <= '0;
      extra_reg  <= 1'b0;
    end else if (tick_os) begin
      cnt_reg    <= '0;
      os_cnt_reg <= os_cnt_reg + 1'b1;
      acc_reg    <= acc_sum[FRAC_W-1:0];
      extra_reg  <= acc_sum[FRAC_W];
    end else if (enable) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // A bus write beats an auto-baud load arriving in the same cycle.
  assign wr_req  = cfg_wr || abd_ld;
  assign wr_div  = cfg_wr ? cfg_div  : abd_div;
  assign wr_frac = cfg_wr ? cfg_frac : abd_frac;

  // Apply only at a bit boundary (or while stopped); a fresh write keeps the
  // newest value pending instead of letting the older one through.
  assign apply = cfg_busy_reg && (tick_bit || !enable) && !wr_req;

  // Shadow and active divisor registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg         <= DIV_W'(DEFAULT_DIV);
      frac_reg        <= FRAC_W'(DEFAULT_FRAC);
      shadow_div_reg  <= DIV_W'(DEFAULT_DIV);
      shadow_frac_reg <= FRAC_W'(DEFAULT_FRAC);
      cfg_busy_reg    <= 1'b0;
    end else if (wr_req) begin
      shadow_div_reg  <= wr_div;
      shadow_frac_reg <= wr_frac;
      cfg_busy_reg    <= 1'b1;
    end else if (apply) begin
      div_reg      <= shadow_div_reg;
      frac_reg     <= shadow_frac_reg;
      cfg_busy_reg <= 1'b0;
    end
  end

`ifdef BAUD_GEN_AUTOBAUD_EN
  baud_autobaud #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W),
    .OVS    (OVS)
  ) u_autobaud (
    .clk     (clk),
    .reset   (reset),
    .start   (abd_start),
    .rxd     (rxd),
    .ld      (abd_ld),
    .ld_div  (abd_div),
    .ld_frac (abd_frac),
    .busy    (abd_busy),
    .err     (abd_err)
  );
`else
  logic unused_abd;
  assign unused_abd = ^{abd_start, rxd};
  assign abd_ld     = 1'b0;
  assign abd_div    = '0;
  assign abd_frac   = '0;
  assign abd_busy   = 1'b0;
  assign abd_err    = 1'b0;
`endif

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: table of divisor settings with expected tick spans,
// hand sequences for config update, sync and enable gaps, and a randomized run
// against a closed-form tick-position model.
module tb_baud_gen_frac;

  localparam int DIV_W  = 8;
  localparam int FRAC_W = 8;
  localparam int OVS    = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              sync = 1'b0;
  logic              cfg_wr = 1'b0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic [FRAC_W-1:0] cfg_frac = '0;
  logic              cfg_busy, tick_os, tick_mid, tick_bit;
  logic              abd_start = 1'b0;
  logic              rxd = 1'b1;
  logic              abd_busy, abd_err;

  int checks = 0;
  int errors = 0;
  logic [2:0] tk;   // {tick_bit, tick_mid, tick_os} sampled mid-cycle
  logic       bsy;  // cfg_busy sampled mid-cycle

  always #5 clk = ~clk;

  baud_gen_frac #(
    .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS), .DEFAULT_DIV(27), .DEFAULT_FRAC(0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sync(sync), .cfg_wr(cfg_wr),
    .cfg_div(cfg_div), .cfg_frac(cfg_frac), .cfg_busy(cfg_busy),
    .tick_os(tick_os), .tick_mid(tick_mid), .tick_bit(tick_bit),
    .abd_start(abd_start), .rxd(rxd), .abd_busy(abd_busy), .abd_err(abd_err)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle; entered and left at posedge+1.
  task automatic cyc(input logic en, input logic sy, input logic wr);
    enable = en; sync = sy; cfg_wr = wr;
    @(negedge clk);
    tk  = {tick_bit, tick_mid, tick_os};
    bsy = cfg_busy;
    @(posedge clk); #1;
    sync = 1'b0; cfg_wr = 1'b0;
  endtask

  // Write a divisor while stopped; it applies one cycle after the write.
  task automatic program_div(input int d, input int f);
    cfg_div = DIV_W'(d); cfg_frac = FRAC_W'(f);
    cyc(1'b0, 1'b0, 1'b1);
    check("cfg_busy_set", int'(cfg_busy), 1);
    cyc(1'b0, 1'b0, 1'b0);
    check("cfg_apply_idle", int'(cfg_busy), 0);
  endtask

  // Restart phase, run enabled until n ticks; report span and bit/mid counts.
  task automatic measure_span(input int n, output int span, output int nbit, output int nmid);
    int cnt;
    cyc(1'b0, 1'b1, 1'b0);
    span = -1; cnt = 0; nbit = 0; nmid = 0;
    for (int t = 1; t <= 4000; t++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (tk[0]) cnt++;
      if (tk[1]) nmid++;
      if (tk[2]) nbit++;
      if (cnt == n) begin
        span = t;
        break;
      end
    end
    enable = 1'b0;
  endtask

  // First tick_os / tick_mid / tick_bit cycle after start with enable held high.
  task automatic first_ticks(input int limit, output int f_os, output int f_mid, output int f_bit);
    f_os = -1; f_mid = -1; f_bit = -1;
    for (int t = 1; t <= limit; t++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (tk[0] && f_os < 0)  f_os = t;
      if (tk[1] && f_mid < 0) f_mid = t;
      if (tk[2] && f_bit < 0) f_bit = t;
    end
    enable = 1'b0;
  endtask

  typedef struct {
    int div;
    int frac;
    int n;
    int span;
    int bits;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int span, nbit, nmid, f_os, f_mid, f_bit;

    vecs[0] = '{4,   0, 8, 32, 2};
    vecs[1] = '{4, 128, 8, 35, 2};
    vecs[2] = '{0,   0, 4,  8, 1};
    vecs[3] = '{1,   0, 4,  8, 1};
    vecs[4] = '{2,  64, 8, 17, 2};
    vecs[5] = '{5, 192, 8, 45, 2};
    vecs[6] = '{3, 255, 4, 14, 1};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_cfg_busy", int'(cfg_busy), 0);
    check("rst_ticks", int'({tick_bit, tick_mid, tick_os}), 0);
    check("rst_abd_busy", int'(abd_busy), 0);
    check("rst_abd_err", int'(abd_err), 0);
    reset = 1'b0;

    // Default divisor 27: first os/mid/bit ticks at 27, 54, 108.
    first_ticks(120, f_os, f_mid, f_bit);
    check("default_first_os", f_os, 27);
    check("default_first_mid", f_mid, 54);
    check("default_first_bit", f_bit, 108);

    // Table of divisor settings.
    for (int i = 0; i < 7; i++) begin
      program_div(vecs[i].div, vecs[i].frac);
      measure_span(vecs[i].n, span, nbit, nmid);
      $display("vec %0d: div=%0d frac=%0d span=%0d bits=%0d mids=%0d",
               i, vecs[i].div, vecs[i].frac, span, nbit, nmid);
      check($sformatf("span_v%0d", i), span, vecs[i].span);
      check($sformatf("bits_v%0d", i), nbit, vecs[i].bits);
      check($sformatf("mids_v%0d", i), nmid, vecs[i].bits);
    end

    // Mid-bit divisor write: old 4-clk spacing until the bit ends at 16.
    program_div(4, 0);
    cyc(1'b0, 1'b1, 1'b0);
    cfg_div = 8'd8; cfg_frac = 8'd0;
    for (int t = 1; t <= 40; t++) begin
      int k;
      logic e_os, e_busy;
      if (t <= 16) begin
        e_os = (t % 4 == 0); k = t / 4 - 1;
      end else begin
        e_os = ((t - 16) % 8 == 0); k = 3 + (t - 16) / 8;
      end
      e_busy = (t >= 7 && t <= 16);
      cyc(1'b1, 1'b0, (t == 6));
      check($sformatf("upd_tick_t%0d", t), int'(tk),
            e_os ? int'({k % OVS == OVS-1, k % OVS == OVS/2-1, 1'b1}) : 0);
      check($sformatf("upd_busy_t%0d", t), int'(bsy), int'(e_busy));
    end
    enable = 1'b0;
    $display("cfg update sequence done");

    // Sync at cnt=2/os_cnt=3 (t=15), then again on a tick cycle (t=35).
    program_div(4, 0);
    cyc(1'b0, 1'b1, 1'b0);
    for (int t = 1; t <= 45; t++) begin
      int last, d, k;
      logic sy, e_os;
      sy   = (t == 15) || (t == 35);
      last = (t > 35) ? 35 : (t > 15) ? 15 : 0;
      d    = t - last;
      e_os = !sy && (d % 4 == 0);
      k    = d / 4 - 1;
      cyc(1'b1, sy, 1'b0);
      check($sformatf("sync_tick_t%0d", t), int'(tk),
            e_os ? int'({k % OVS == OVS-1, k % OVS == OVS/2-1, 1'b1}) : 0);
    end
    enable = 1'b0;
    $display("sync sequence done");

    // Enable low for 10 clocks at cnt=1: the held interval finishes later.
    program_div(4, 0);
    cyc(1'b0, 1'b1, 1'b0);
    begin
      int e_cnt;
      e_cnt = 0;
      for (int t = 1; t <= 30; t++) begin
        logic en;
        en = !(t >= 2 && t <= 11);
        if (en) e_cnt++;
        cyc(en, 1'b0, 1'b0);
        check($sformatf("hold_os_t%0d", t), int'(tk[0]), int'(en && (e_cnt % 4 == 0)));
      end
    end
    enable = 1'b0;
    $display("enable hold sequence done");

    // Randomized run against closed-form tick positions.
    for (int r = 0; r < 6; r++) begin
      int d, f, deff, e_cnt, k, fails0;
      d = $urandom_range(0, 12);
      f = $urandom_range(0, 255);
      deff = (d < 2) ? 2 : d;
      program_div(d, f);
      cyc(1'b0, 1'b1, 1'b0);
      e_cnt = 0; k = 0; fails0 = errors;
      for (int t = 0; t < 250; t++) begin
        logic en, sy;
        int exp;
        en  = ($urandom_range(0, 3) != 0);
        sy  = ($urandom_range(0, 49) == 0);
        exp = 0;
        if (sy) begin
          e_cnt = 0; k = 0;
        end else if (en) begin
          e_cnt++;
          // Tick k ends after (k+1)*div_eff + floor(k*frac/2^FRAC_W) enabled cycles.
          if (e_cnt == (k + 1) * deff + (k * f) / (1 << FRAC_W)) begin
            exp = int'({k % OVS == OVS-1, k % OVS == OVS/2-1, 1'b1});
            k++;
          end
        end
        cyc(en, sy, 1'b0);
        check($sformatf("rand_r%0d_t%0d", r, t), int'(tk), exp);
      end
      $display("random round %0d: div=%0d frac=%0d ticks=%0d errors=%0d",
               r, d, f, k, errors - fails0);
    end
    enable = 1'b0;

    // Asynchronous reset clears a pending update without a clock edge.
    cfg_div = 8'd9;
    cyc(1'b1, 1'b0, 1'b1);
    check("pending_before_reset", int'(cfg_busy), 1);
    reset = 1'b1;
    #1;
    check("async_reset_busy", int'(cfg_busy), 0);
    check("async_reset_ticks", int'({tick_bit, tick_mid, tick_os}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    first_ticks(30, f_os, f_mid, f_bit);
    check("reset_restores_div", f_os, 27);

`ifdef BAUD_GEN_AUTOBAUD_EN
    begin
      int m, e_div, e_frac, e_span;
      m      = 435;
      e_div  = m / OVS;
      e_frac = ((m % OVS) * (1 << FRAC_W)) / OVS;
      e_span = 8 * e_div + (7 * e_frac) / (1 << FRAC_W);

      abd_start = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      abd_start = 1'b0;
      check("abd_busy_set", int'(abd_busy), 1);
      check("abd_err_clear", int'(abd_err), 0);
      rxd = 1'b0;
      repeat (m) cyc(1'b0, 1'b0, 1'b0);
      rxd = 1'b1;
      for (int i = 0; i < 10; i++) begin
        cyc(1'b0, 1'b0, 1'b0);
        if (!abd_busy) break;
      end
      check("abd_busy_done", int'(abd_busy), 0);
      check("abd_loaded_shadow", int'(cfg_busy), 1);
      cyc(1'b0, 1'b0, 1'b0);
      check("abd_applied", int'(cfg_busy), 0);
      measure_span(8, span, nbit, nmid);
      $display("autobaud M=%0d span=%0d", m, span);
      check("abd_span", span, e_span);

      // Low pulse longer than the counter range: error, divisor untouched.
      abd_start = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      abd_start = 1'b0;
      rxd = 1'b0;
      repeat ((1 << (DIV_W + $clog2(OVS))) + 60) cyc(1'b0, 1'b0, 1'b0);
      rxd = 1'b1;
      repeat (4) cyc(1'b0, 1'b0, 1'b0);
      check("abd_ovf_busy", int'(abd_busy), 0);
      check("abd_ovf_err", int'(abd_err), 1);
      check("abd_ovf_no_load", int'(cfg_busy), 0);
      measure_span(8, span, nbit, nmid);
      check("abd_ovf_span", span, e_span);
      abd_start = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      abd_start = 1'b0;
      check("abd_err_cleared", int'(abd_err), 0);
    end
`else
    abd_start = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    abd_start = 1'b0;
    rxd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      check($sformatf("abd_off_%0d", i), int'({abd_busy, abd_err, bsy}), 0);
    end
    rxd = 1'b1;
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    check("abd_off_no_load", int'(cfg_busy), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
Programmable fractional baud-rate generator for the UART peripherals. It replaces the fixed-count tick generator. It produces an oversample tick, a mid-bit tick and a bit tick from a runtime divisor with a fractional part. It also supports phase resync for receivers and safe divisor updates from the bus-side config registers.

Parameters:
DIV_W, 16, integer divisor width (clk cycles per oversample tick)
FRAC_W, 8, fractional divisor width (units of 1/2^FRAC_W cycle)
OVS, 16, oversample ticks per bit; power of two, >=4
DEFAULT_DIV, 27, integer divisor after reset
DEFAULT_FRAC, 0, fractional divisor after reset

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run counters; low = hold state, no ticks
sync  in  1  one-cycle pulse: restart tick phase (RX start-bit edge)
cfg_wr  in  1  one-cycle strobe: write shadow divisor
cfg_div  in  DIV_W  integer divisor to write
cfg_frac  in  FRAC_W  fractional divisor to write
cfg_busy  out  1  shadow written but not yet applied
tick_os  out  1  oversample tick, one-cycle pulse
tick_mid  out  1  mid-bit tick (coincides with tick_os)
tick_bit  out  1  bit-boundary tick (coincides with tick_os)
abd_start  in  1  start auto-baud measurement (optional feature)
rxd  in  1  synchronised serial input for auto-baud
abd_busy  out  1  auto-baud in progress
abd_err  out  1  sticky: last auto-baud overflowed; cleared by abd_start

Behaviour:
- Reset:
  - Active div/frac = DEFAULT_DIV/DEFAULT_FRAC.
  - cnt, os_cnt, acc, extra = 0.
  - All outputs 0.
- Effective integer divisor: max(div, 2). Values 0 and 1 clamp to 2.
- Period of the current oversample interval: P = div_eff + extra, where extra is 0 or 1.
- cnt counts 0..P-1. tick_os = enable && cnt == P-1. On tick_os, cnt returns to 0.
- On each tick_os:
  - {carry, acc} <= acc + frac (FRAC_W+1-bit add).
  - extra <= carry, which takes effect for the next interval.
- os_cnt counts tick_os modulo OVS.
  - tick_bit = tick_os && os_cnt == OVS-1.
  - tick_mid = tick_os && os_cnt == OVS/2-1.
- enable low: cnt, os_cnt, acc, extra hold; no ticks. Resuming continues from the held phase.
- sync high: next cycle cnt, os_cnt, acc, extra = 0. No tick is output in the sync cycle. sync is effective regardless of enable.
- Priority: reset > sync > normal counting.
- Divisor update:
  - cfg_wr loads the shadow registers and sets cfg_busy.
  - Shadow copies to active div/frac on the cycle after a tick_bit, or on the next cycle if enable is low. cfg_busy clears on that same cycle.
  - cfg_wr while busy overwrites the shadow; cfg_busy stays high.
  - cfg_wr in the same cycle as an apply: the new value wins and stays pending.
  - Update never shortens or splits a bit in progress.
- Width rules: cnt is DIV_W+1 bits, so div_eff+1 cannot overflow. All arithmetic is unsigned.

Optional Feature:
Macro BAUD_GEN_AUTOBAUD_EN.
- With the macro: auto-baud FSM with states IDLE, WAIT_FALL, MEASURE, LOAD.
  - IDLE --abd_start--> WAIT_FALL: sets abd_busy and clears abd_err.
  - WAIT_FALL --rxd 1->0--> MEASURE.
  - MEASURE counts clk cycles M while rxd=0. On rxd 0->1 go to LOAD.
  - LOAD writes the shadow: cfg_div = M >> log2(OVS); cfg_frac = (M mod OVS) scaled to FRAC_W bits. LOAD goes to IDLE. The normal apply rule then takes effect.
  - If M reaches 2^(DIV_W+log2(OVS))-1: abd_err=1, shadow untouched, return to IDLE.
  - abd_start while busy restarts at WAIT_FALL.
  - cfg_wr in the LOAD cycle takes precedence.
- Without the macro: abd_start and rxd are ignored; abd_busy=0 and abd_err=0 constant.

Decomposition:
- Shared package uart_pkg holds:
  - DIV_W and FRAC_W defaults.
  - Auto-baud state encoding typedef abd_state_t.
  - Min-divisor constant BAUD_MIN_DIV=2.
- The natural sub-module is baud_autobaud (the measurement FSM), instantiated under the macro.

Test Plan:
- Reset release, div=4, frac=0, OVS=4, enable=1 -> first tick_os on the 4th clk; tick_os every 4 clks; tick_mid at os_cnt=1; tick_bit every 16 clks.
- div=4, frac=128 (FRAC_W=8) -> interval lengths 4,4,5,4,5,4,5,4; first 8 tick_os span 35 clks.
- cfg_wr div=8 mid-bit -> cfg_busy=1 until the cycle after tick_bit; old 4-clk spacing holds until then; 8-clk spacing after.
- sync pulse at cnt=2, os_cnt=3 -> no tick that cycle; next tick_os exactly div_eff clks after sync release; os_cnt restarts at 0.
- enable low for 10 clks at cnt=1 -> no ticks; remaining interval completes after enable returns; div=0 and div=1 behave as div=2.
- (macro on) abd_start, rxd low for 435 clks, OVS=16 -> div=27, frac=(3/16)*256=48, abd_busy clears. Low held past counter max -> abd_err=1 and divisor unchanged.
